// File: rtl/dpram_pkg.sv
// -----------------------------------------------------------------------------
// dpram_pkg
//   Shared definitions for the byte-enable dual-port RAM (dpram_be_sync).
//   - clog2          : ceiling log2 for sizing counters from a depth
//   - dpram_state_e  : clear-sweep FSM encoding (ST_CLEAR, ST_READY)
//   - byte_merge     : per-byte select of new vs. old data, used by both the
//                      write path and the same-cycle read bypass so the two can
//                      never disagree on how byte enables are applied
//   byte_merge operates on a fixed maximum width; callers zero-extend their
//   operands and size-cast the result back to their own word width.
// -----------------------------------------------------------------------------
package dpram_pkg;

  localparam int unsigned MAX_DATA_WIDTH = 1024;
  localparam int unsigned MAX_BE_WIDTH   = MAX_DATA_WIDTH / 8;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } dpram_state_e;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned v;
    int unsigned r;
    r = 0;
    v = (value > 0) ? value - 1 : 0;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

  function automatic logic [MAX_DATA_WIDTH-1:0] byte_merge(
    input logic [MAX_DATA_WIDTH-1:0] old_w,
    input logic [MAX_DATA_WIDTH-1:0] new_w,
    input logic [MAX_BE_WIDTH-1:0]   be
  );
    logic [MAX_DATA_WIDTH-1:0] res;
    res = old_w;
    for (int unsigned i = 0; i < MAX_BE_WIDTH; i++) begin
      if (be[i]) begin
        res[8*i +: 8] = new_w[8*i +: 8];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/dpram_rd_pipe.sv
// -----------------------------------------------------------------------------
// dpram_rd_pipe
//   One valid+data register stage of the RAM read pipeline. The top level
//   chains RD_LATENCY of these.
//   STATE_KEEP=1 : data holds its last value while valid_i is low.
//   STATE_KEEP=0 : data is cleared whenever valid_i is low.
// Ports
//   clk      in   rising-edge clock
//   rst_n    in   asynchronous active-low reset (clears valid and data)
//   valid_i  in   stage input valid
//   data_i   in   stage input data
//   valid_o  out  registered valid
//   data_o   out  registered data
// -----------------------------------------------------------------------------
module dpram_rd_pipe #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned STATE_KEEP = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  valid_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic                  valid_o,
  output logic [DATA_WIDTH-1:0] data_o
);

  logic                  valid_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic [DATA_WIDTH-1:0] data_d;

  always_comb begin
    data_d = data_q;
    if (valid_i) begin
      data_d = data_i;
    end else if (STATE_KEEP == 0) begin
      data_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_i;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/dpram_be_sync.sv
// -----------------------------------------------------------------------------
// dpram_be_sync
//   Single-clock RAM with one write port and one read port, per-byte write
//   enables, 1- or 2-cycle registered read with a valid strobe, optional
//   same-cycle write->read bypass and optional zeroing sweep after reset.
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset (memory array is not reset)
//   re         in   read request
//   raddr      in   read address
//   we         in   write request
//   wbe        in   byte enables, bit i covers din[8i+7:8i]
//   waddr      in   write address
//   din        in   write data
//   dout       out  read data
//   rvalid     out  dout holds a read issued RD_LATENCY cycles earlier
//   init_busy  out  clear sweep running; re/we are ignored while high
// -----------------------------------------------------------------------------
module dpram_be_sync
  import dpram_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 8,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned RD_LATENCY     = 1,
  parameter int unsigned ENABLE_BYPASS  = 1,
  parameter int unsigned STATE_KEEP     = 1,
  parameter int unsigned CLEAR_ON_RESET = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    re,
  input  logic [ADDR_WIDTH-1:0]   raddr,
  input  logic                    we,
  input  logic [DATA_WIDTH/8-1:0] wbe,
  input  logic [ADDR_WIDTH-1:0]   waddr,
  input  logic [DATA_WIDTH-1:0]   din,
  output logic [DATA_WIDTH-1:0]   dout,
  output logic                    rvalid,
  output logic                    init_busy
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
  localparam int unsigned CLR_W = clog2(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  dpram_state_e          state_q;
  logic [CLR_W-1:0]      clr_addr_q;
  logic                  init_busy_q;

  logic                  rd_acc;
  logic                  wr_acc;
  logic                  collide;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic [DATA_WIDTH-1:0] wr_word;
  logic [DATA_WIDTH-1:0] rd_word_d;

  // Clear sweep: one word per cycle; leaves CLEAR on the edge that writes
  // the last address, so busy spans exactly DEPTH cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
      clr_addr_q  <= '0;
      init_busy_q <= (CLEAR_ON_RESET != 0);
    end else begin
      if (state_q == ST_CLEAR) begin
        clr_addr_q <= clr_addr_q + CLR_W'(1);
        if (clr_addr_q == '1) begin
          state_q     <= ST_READY;
          init_busy_q <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    rd_acc    = re & ~init_busy_q;
    wr_acc    = we & ~init_busy_q;
    mem_rdata = mem[raddr];
    wr_word   = DATA_WIDTH'(byte_merge(MAX_DATA_WIDTH'(mem[waddr]),
                                       MAX_DATA_WIDTH'(din),
                                       MAX_BE_WIDTH'(wbe)));
  end

  // Sweep has the port to itself while busy; user writes are dropped then.
  always_ff @(posedge clk) begin
    if (init_busy_q) begin
      mem[clr_addr_q] <= '0;
    end else if (wr_acc) begin
      mem[waddr] <= wr_word;
    end
  end

  // On a same-address collision wr_word is exactly old bytes merged with din,
  // so the bypass value reuses the write-path merge.
  always_comb begin
    collide   = (ENABLE_BYPASS != 0) && wr_acc && rd_acc && (waddr == raddr);
    rd_word_d = collide ? wr_word : mem_rdata;
  end

  logic [RD_LATENCY:0]   pipe_v;
  logic [DATA_WIDTH-1:0] pipe_d [RD_LATENCY+1];

  assign pipe_v[0] = rd_acc;
  assign pipe_d[0] = rd_word_d;

  for (genvar g = 0; g < RD_LATENCY; g++) begin : g_stage
    dpram_rd_pipe #(
      .DATA_WIDTH (DATA_WIDTH),
      .STATE_KEEP (STATE_KEEP)
    ) u_stage (
      .clk     (clk),
      .rst_n   (rst_n),
      .valid_i (pipe_v[g]),
      .data_i  (pipe_d[g]),
      .valid_o (pipe_v[g+1]),
      .data_o  (pipe_d[g+1])
    );
  end

  assign dout      = pipe_d[RD_LATENCY];
  assign rvalid    = pipe_v[RD_LATENCY];
  assign init_busy = init_busy_q;

endmodule
